fft_mag_peak_finder: RTL and testbench

//   Consumer at the downstream end of the FFT magnitude-squared stream (mag_valid/mag_sq).

---
 rtl/fft_mag_peak_finder.sv | 151 +++++++++++++++
 tb/tb_fft_mag_peak_finder.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_peak_finder.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag_peak_finder
// Purpose  : Consumes the FFT magnitude-squared stream, groups samples into
//            frames of N_BINS bins and reports per frame the peak magnitude,
//            its bin index and the frame energy (sum of all bins) on a
//            valid/ready result port.
// Ports    : clk            - clock
//            reset          - synchronous, active-low reset
//            mag_valid_i    - input sample qualifier
//            mag_sof_i      - first bin of frame (qualified by mag_valid_i)
//            mag_sq_i       - unsigned magnitude squared, 2*W+1 bits
//            peak_valid_o   - result available, held until accepted
//            peak_ready_i   - downstream accepts result
//            peak_mag_o     - largest magnitude in the frame
//            peak_idx_o     - bin index of peak_mag_o (earliest on ties)
//            frame_energy_o - sum of all N_BINS magnitudes
//            frame_err_o    - 1-cycle pulse: start of frame before completion
//            overrun_o      - 1-cycle pulse: result dropped, output busy
// Revision : 1.0 - initial release
// ============================================================================
module fft_mag_peak_finder #(
   parameter int W      = 16,
   parameter int N_BINS = 16,
   parameter int IDX_W  = $clog2(N_BINS),
   parameter int E_W    = 2*W+1+IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             mag_valid_i,
   input  logic             mag_sof_i,
   input  logic [2*W:0]     mag_sq_i,
   output logic             peak_valid_o,
   input  logic             peak_ready_i,
   output logic [2*W:0]     peak_mag_o,
   output logic [IDX_W-1:0] peak_idx_o,
   output logic [E_W-1:0]   frame_energy_o,
   output logic             frame_err_o,
   output logic             overrun_o
);

   localparam int             MAG_W    = 2*W+1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BINS-1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t             state_q;
   logic [IDX_W-1:0]   bin_cnt_q;
   logic [MAG_W-1:0]   cur_max_q;
   logic [IDX_W-1:0]   cur_idx_q;
   logic [E_W-1:0]     acc_q;

   logic               peak_valid_q;
   logic [MAG_W-1:0]   peak_mag_q;
   logic [IDX_W-1:0]   peak_idx_q;
   logic [E_W-1:0]     frame_energy_q;
   logic               frame_err_q;
   logic               overrun_q;

   // Running-frame values including the current sample (continuation bin).
   logic [MAG_W-1:0]   max_d;
   logic [IDX_W-1:0]   idx_d;
   logic [E_W-1:0]     acc_d;
   logic [IDX_W-1:0]   bin_cnt_d;
   logic               last_bin;
   logic               out_free;

   always_comb begin
      max_d     = cur_max_q;
      idx_d     = cur_idx_q;
      // Strict compare: ties keep the earlier bin index.
      if (mag_sq_i > cur_max_q) begin
         max_d = mag_sq_i;
         idx_d = bin_cnt_q;
      end
      acc_d     = acc_q + E_W'(mag_sq_i);
      bin_cnt_d = bin_cnt_q + 1'b1;
      last_bin  = (bin_cnt_q == LAST_IDX);
      // The output slot can take a new result if empty or being drained now.
      out_free  = !peak_valid_q || peak_ready_i;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         bin_cnt_q      <= '0;
         cur_max_q      <= '0;
         cur_idx_q      <= '0;
         acc_q          <= '0;
         peak_valid_q   <= 1'b0;
         peak_mag_q     <= '0;
         peak_idx_q     <= '0;
         frame_energy_q <= '0;
         frame_err_q    <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;

         // Handshake drain; a completion below on the same edge overrides it.
         if (peak_valid_q && peak_ready_i) begin
            peak_valid_q <= 1'b0;
         end

         if (mag_valid_i) begin
            if (mag_sof_i) begin
               // Start of frame in either state restarts at bin 0.
               if (state_q == ACCUM) begin
                  frame_err_q <= 1'b1;
               end
               state_q   <= ACCUM;
               cur_max_q <= mag_sq_i;
               cur_idx_q <= '0;
               acc_q     <= E_W'(mag_sq_i);
               bin_cnt_q <= IDX_W'(1);
            end else if (state_q == ACCUM) begin
               if (last_bin) begin
                  state_q   <= IDLE;
                  bin_cnt_q <= '0;
                  if (out_free) begin
                     peak_valid_q   <= 1'b1;
                     peak_mag_q     <= max_d;
                     peak_idx_q     <= idx_d;
                     frame_energy_q <= acc_d;
                  end else begin
                     overrun_q <= 1'b1;
                  end
               end else begin
                  bin_cnt_q <= bin_cnt_d;
               end
               cur_max_q <= max_d;
               cur_idx_q <= idx_d;
               acc_q     <= acc_d;
            end
            // IDLE without start of frame: sample dropped silently.
         end
      end
   end

   assign peak_valid_o   = peak_valid_q;
   assign peak_mag_o     = peak_mag_q;
   assign peak_idx_o     = peak_idx_q;
   assign frame_energy_o = frame_energy_q;
   assign frame_err_o    = frame_err_q;
   assign overrun_o      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_mag_peak_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_mag_peak_finder
// Purpose  : Self-checking bench for fft_mag_peak_finder with N_BINS=4, W=16.
//            Table of per-cycle vectors for the basic, tie/gap and early
//            start-of-frame cases; hand sequences for backpressure,
//            accept-with-completion and mid-frame reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_mag_peak_finder;

   localparam int W      = 16;
   localparam int N_BINS = 4;
   localparam int IDX_W  = 2;
   localparam int E_W    = 2*W+1+IDX_W;

   logic             clk = 1'b0;
   logic             reset;
   logic             mag_valid_i;
   logic             mag_sof_i;
   logic [2*W:0]     mag_sq_i;
   logic             peak_valid_o;
   logic             peak_ready_i;
   logic [2*W:0]     peak_mag_o;
   logic [IDX_W-1:0] peak_idx_o;
   logic [E_W-1:0]   frame_energy_o;
   logic             frame_err_o;
   logic             overrun_o;

   fft_mag_peak_finder #(
      .W      (W),
      .N_BINS (N_BINS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .mag_valid_i    (mag_valid_i),
      .mag_sof_i      (mag_sof_i),
      .mag_sq_i       (mag_sq_i),
      .peak_valid_o   (peak_valid_o),
      .peak_ready_i   (peak_ready_i),
      .peak_mag_o     (peak_mag_o),
      .peak_idx_o     (peak_idx_o),
      .frame_energy_o (frame_energy_o),
      .frame_err_o    (frame_err_o),
      .overrun_o      (overrun_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic        sof;
      logic [63:0] m;
      logic        rdy;
      logic        pv;
      logic [63:0] pm;
      logic [63:0] pi;
      logic [63:0] pe;
      logic        fe;
      logic        ov;
   } vec_t;

   vec_t tbl[$];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic void add(input logic v, input logic sof, input logic [63:0] m,
                               input logic rdy, input logic pv, input logic [63:0] pm,
                               input logic [63:0] pi, input logic [63:0] pe,
                               input logic fe, input logic ov);
      vec_t r;
      r.v = v; r.sof = sof; r.m = m; r.rdy = rdy; r.pv = pv;
      r.pm = pm; r.pi = pi; r.pe = pe; r.fe = fe; r.ov = ov;
      tbl.push_back(r);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      else
         n_pass++;
   endtask

   task automatic chk_all(input string tag, input logic pv, input logic [63:0] pm,
                          input logic [63:0] pi, input logic [63:0] pe,
                          input logic fe, input logic ov);
      chk({tag, ".peak_valid"},   64'(peak_valid_o),   64'(pv));
      chk({tag, ".peak_mag"},     64'(peak_mag_o),     pm);
      chk({tag, ".peak_idx"},     64'(peak_idx_o),     pi);
      chk({tag, ".frame_energy"}, 64'(frame_energy_o), pe);
      chk({tag, ".frame_err"},    64'(frame_err_o),    64'(fe));
      chk({tag, ".overrun"},      64'(overrun_o),      64'(ov));
   endtask

   // Apply inputs for one clock edge and sample 1 time unit after it.
   task automatic step(input logic v, input logic sof, input logic [63:0] m, input logic rdy);
      mag_valid_i  = v;
      mag_sof_i    = sof;
      mag_sq_i     = m[2*W:0];
      peak_ready_i = rdy;
      @(posedge clk);
      #1;
   endtask

   localparam logic [63:0] P1 = 64'd1857102416;
   localparam logic [63:0] E1 = 64'd4114535160;

   initial begin
      reset        = 1'b0;
      mag_valid_i  = 1'b0;
      mag_sof_i    = 1'b0;
      mag_sq_i     = '0;
      peak_ready_i = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk_all("reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b1;

      // Basic frame
      add(1,1,64'd1452565792,1, 0,0,0,0,0,0);
      add(1,0,64'd184557332, 1, 0,0,0,0,0,0);
      add(1,0,P1,            1, 0,0,0,0,0,0);
      add(1,0,64'd620309620, 1, 1,P1,2,E1,0,0);
      add(0,0,0,             1, 0,P1,2,E1,0,0);
      // Ties with valid gaps
      add(1,1,5,1, 0,P1,2,E1,0,0);
      add(0,0,0,1, 0,P1,2,E1,0,0);
      add(1,0,5,1, 0,P1,2,E1,0,0);
      add(0,0,0,1, 0,P1,2,E1,0,0);
      add(0,0,0,1, 0,P1,2,E1,0,0);
      add(1,0,5,1, 0,P1,2,E1,0,0);
      add(0,0,0,1, 0,P1,2,E1,0,0);
      add(1,0,5,1, 1,5,0,20,0,0);
      add(0,0,0,1, 0,5,0,20,0,0);
      // Sample without start of frame in IDLE is dropped quietly
      add(1,0,99,1, 0,5,0,20,0,0);
      // Early start of frame
      add(1,1,10,1, 0,5,0,20,0,0);
      add(1,0,20,1, 0,5,0,20,0,0);
      add(1,1,1, 1, 0,5,0,20,1,0);
      add(1,0,2, 1, 0,5,0,20,0,0);
      add(1,0,3, 1, 0,5,0,20,0,0);
      add(1,0,4, 1, 1,4,3,10,0,0);
      add(0,0,0, 1, 0,4,3,10,0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].v, tbl[i].sof, tbl[i].m, tbl[i].rdy);
         chk_all($sformatf("vec%0d", i), tbl[i].pv, tbl[i].pm, tbl[i].pi,
                 tbl[i].pe, tbl[i].fe, tbl[i].ov);
      end

      // Backpressure across two back-to-back frames
      step(1,1,8,0); step(1,0,1,0); step(1,0,2,0); step(1,0,3,0);
      chk_all("bp_f1", 1, 8, 0, 14, 0, 0);
      step(1,1,1,0);
      chk_all("bp_f2_sof", 1, 8, 0, 14, 0, 0);
      step(1,0,9,0); step(1,0,1,0); step(1,0,1,0);
      chk_all("bp_f2_done", 1, 8, 0, 14, 0, 1);
      step(0,0,0,0);
      chk_all("bp_hold", 1, 8, 0, 14, 0, 0);
      step(0,0,0,1);
      chk_all("bp_drain", 0, 8, 0, 14, 0, 0);

      // Accept on the same edge as a completion
      step(1,1,2,0); step(1,0,2,0); step(1,0,2,0); step(1,0,2,0);
      chk_all("acc_f1", 1, 2, 0, 8, 0, 0);
      step(1,1,1,0); step(1,0,1,0); step(1,0,6,0); step(1,0,1,1);
      chk_all("acc_f2", 1, 6, 2, 9, 0, 0);
      step(0,0,0,0);
      chk_all("acc_hold", 1, 6, 2, 9, 0, 0);
      step(0,0,0,1);
      chk_all("acc_drain", 0, 6, 2, 9, 0, 0);

      // Reset in the middle of a frame
      step(1,1,5,1); step(1,0,6,1);
      reset = 1'b0;
      step(0,0,0,1);
      chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      step(1,1,7,1);
      chk_all("rst_b0", 0, 0, 0, 0, 0, 0);
      step(1,0,9,1); step(1,0,3,1); step(1,0,1,1);
      chk_all("rst_frame", 1, 9, 1, 20, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
